weight_loader_cxy: RTL and testbench
====================================

# weight_loader_cxy

Write-side driver for the CNN vector multiplier's weight bank. Pulls a stream of DW-bit weight words from an upstream valid/ready source, writes them to the multiplier's weight port with the port's required one-cycle data lag, and optionally reads the written region back. Readback is checked against a rotating-XOR signature, and the block reports DONE and ERR to the layer controller.

## Interface
- DIM, 16, weights per phase (power of two, DIM = 2^AW)
- AW, 4, per-phase address width
- DW, 24, weight word width

- CLK  in  1  clock
- RSTn  in  1  reset, synchronous, active-low
- START  in  1  load request, sampled only while BUSY=0
- LOAD_ALL  in  1  1: load all 8 phases (DIM*8 words); 0: load phase PHASE only (DIM words); latched on START
- PHASE  in  3  target phase when LOAD_ALL=0; latched on START
- VERIFY  in  1  1: read back and check after the write pass; latched on START
- S_VALID  in  1  upstream word valid
- S_DATA  in  DW  upstream weight word
- S_READY  out  1  high only in write phase
- W_WEN  out  1  weight write enable
- W_REN  out  1  weight read enable
- W_ADDR  out  AW+3  weight address, shared by write and read
- W_WDATA  out  DW  write data, lags W_WEN/W_ADDR by exactly one cycle
- W_RDATA  in  DW  read data, valid the cycle after W_REN
- BUSY  out  1  load in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  signature mismatch, sticky until the next accepted START

## Operation
- States: IDLE, WRITE, DRAIN, READ, CHECK.
- IDLE:
  - START with BUSY=0 latches the configuration.
  - Sets N = LOAD_ALL ? DIM*8 : DIM and base = LOAD_ALL ? 0 : {PHASE, AW'b0}.
  - Clears both signatures and ERR, then enters WRITE.
  - START while BUSY=1 is ignored.
- WRITE:
  - S_READY=1.
  - Each handshake (S_VALID & S_READY at a rising edge) consumes one word for address base+i, with i counting 0..N-1.
  - Signature update: wr_sig = rotl1(wr_sig) ^ S_DATA.
  - Cycles with S_VALID=0 produce W_WEN=0 and no address advance.
  - After handshake N, S_READY drops in the next cycle and the state goes to DRAIN.
- DRAIN: waits until the final write has committed in the multiplier. VERIFY=0 then goes to CHECK, otherwise to READ.
- READ:
  - W_REN=1 for N consecutive cycles, with W_ADDR = base+j for j = 0..N-1.
  - Each W_RDATA, in the cycle after its W_REN, updates rd_sig = rotl1(rd_sig) ^ W_RDATA.
- CHECK:
  - One cycle with DONE=1 and BUSY=0; the state returns to IDLE.
  - If VERIFY=1, ERR is set when rd_sig != wr_sig; ERR is held 0 when VERIFY=0.
- Signatures are DW bits wide, with rotl1 = {sig[DW-2:0], sig[DW-1]}. Both passes run in ascending address order, so a swapped or stuck address changes the signature.
- W_WEN and W_REN are never high in the same cycle.
- W_WDATA holds its last value when no write data is due.
- Reset values: S_READY=0, W_WEN=0, W_REN=0, W_ADDR=0, W_WDATA=0, BUSY=0, DONE=0, ERR=0. Signatures and counters are 0, and the state is IDLE.
- Reset mid-operation:
  - The block returns to IDLE in the next cycle and any remaining upstream words are left unconsumed.
  - A write whose W_WEN appeared in the reset cycle commits W_WDATA=0 to its address. This is accepted behaviour; the controller reloads after reset.

## Timing
- All outputs are registered.
- START accepted at the end of cycle s: BUSY=1 and S_READY=1 in cycle s+1.
- Handshake at the end of cycle c: W_WEN=1 and W_ADDR=base+i in cycle c+1; W_WDATA = that word in cycle c+2.
- Throughput: one word per cycle when S_VALID is held high, so N back-to-back handshakes take N cycles.
- Last handshake in cycle c:
  - The multiplier commits it at the end of c+2.
  - With VERIFY=1, the first W_REN is in cycle c+3.
  - With VERIFY=0, DONE is in cycle c+3.
- Last W_REN in cycle r: its W_RDATA arrives in cycle r+1, and DONE and the ERR update occur in cycle r+2.
- BUSY falls in the DONE cycle. A START in the DONE cycle is accepted.
- Minimum load time with VERIFY=1 and no stalls: 1 + N + 2 + N + 2 cycles from START to DONE.

## Test plan
- Single-phase load, no stalls: LOAD_ALL=0, PHASE=5, VERIFY=0, DIM=16 words 0x000001..0x000010. Require W_ADDR 0x50..0x5F with W_WEN, W_WDATA one cycle behind, and DONE 3 cycles after the last handshake. The multiplier model must hold the words at 80..95.
- Full load with verify: LOAD_ALL=1, 128 words with values equal to their address. Require 128 contiguous W_REN, ERR=0, and DONE exactly 2 cycles after the last W_REN.
- Backpressure: S_VALID toggling 1,0,0,1 on a phase-2 load. Require no W_WEN in gap cycles, correct addresses 0x20..0x2F, and the memory contents matching.
- Readback corruption: the bench memory model flips bit 0 of the word at address 0x33 on read, during a phase-3 load with VERIFY=1. Require DONE with ERR=1; ERR stays 1 until the next START, and a following clean load clears it.
- Reset mid-write: assert RSTn=0 after 5 handshakes. Require all outputs 0 in the next cycle and S_READY to stay 0. A new START then completes normally.
- START while BUSY: pulse START during READ. Require no effect on the address sequence, and only one DONE.

Source files
------------

// File: rtl/weight_loader_cxy.sv
// Weight-bank write driver: streams upstream words into the multiplier weight port
// (data one cycle behind enable/address), optionally reads the region back and checks a rotating-XOR signature.
module weight_loader_cxy #(
  parameter int DIM = 16,
  parameter int AW  = 4,
  parameter int DW  = 24
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            START,
  input  logic            LOAD_ALL,
  input  logic [2:0]      PHASE,
  input  logic            VERIFY,
  input  logic            S_VALID,
  input  logic [DW-1:0]   S_DATA,
  output logic            S_READY,
  output logic            W_WEN,
  output logic            W_REN,
  output logic [AW+2:0]   W_ADDR,
  output logic [DW-1:0]   W_WDATA,
  input  logic [DW-1:0]   W_RDATA,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR
);
  // state | meaning
  // IDLE  | waiting for START
  // WRITE | accepting upstream words, one write per handshake
  // DRAIN | two cycles while the last write data reaches the bank
  // READ  | N reads issued, plus one cycle to absorb the last read data
  // CHECK | DONE pulse, ERR updated; a new START is accepted here
  localparam int CW = AW + 4;
  localparam int MW = AW + 3;

  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, READ, CHECK} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx, n_words;
  logic [MW-1:0]   base, base_nx, w_addr_nx;
  logic            load_all_q, load_all_nx, verify_q, verify_nx;
  logic            drain_q, drain_nx, rd_pend;
  logic [DW-1:0]   wr_sig, wr_sig_nx, rd_sig, rd_sig_nx;
  logic [DW-1:0]   data_q, data_nx, w_wdata_nx;
  logic            s_ready_nx, w_wen_nx, w_ren_nx, busy_nx, done_nx, err_nx;
  logic            hs;

  function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] v);
    return {v[DW-2:0], v[DW-1]};
  endfunction

  assign n_words = load_all_q ? CW'(DIM * 8) : CW'(DIM);
  assign hs      = S_READY & S_VALID;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    base_nx     = base;
    load_all_nx = load_all_q;
    verify_nx   = verify_q;
    drain_nx    = drain_q;
    wr_sig_nx   = wr_sig;
    rd_sig_nx   = rd_pend ? (rotl1(rd_sig) ^ W_RDATA) : rd_sig;
    data_nx     = data_q;
    s_ready_nx  = 1'b0;
    w_wen_nx    = 1'b0;
    w_ren_nx    = 1'b0;
    w_addr_nx   = W_ADDR;
    w_wdata_nx  = W_WEN ? data_q : W_WDATA;
    busy_nx     = BUSY;
    done_nx     = 1'b0;
    err_nx      = ERR;
    case (state)
      IDLE, CHECK: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        if (START) begin
          load_all_nx = LOAD_ALL;
          verify_nx   = VERIFY;
          base_nx     = LOAD_ALL ? '0 : {PHASE, {AW{1'b0}}};
          cnt_nx      = '0;
          wr_sig_nx   = '0;
          rd_sig_nx   = '0;
          err_nx      = 1'b0;
          state_nx    = WRITE;
          s_ready_nx  = 1'b1;
          busy_nx     = 1'b1;
        end
      end
      WRITE: begin
        s_ready_nx = 1'b1;
        if (hs) begin
          w_wen_nx  = 1'b1;
          w_addr_nx = base + cnt[MW-1:0];
          data_nx   = S_DATA;
          wr_sig_nx = rotl1(wr_sig) ^ S_DATA;
          cnt_nx    = cnt + CW'(1);
          if (cnt == n_words - CW'(1)) begin
            state_nx   = DRAIN;
            s_ready_nx = 1'b0;
            drain_nx   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!drain_q) begin
          drain_nx = 1'b1;
        end else if (verify_q) begin
          state_nx  = READ;
          cnt_nx    = CW'(1);
          w_ren_nx  = 1'b1;
          w_addr_nx = base;
        end else begin
          state_nx = CHECK;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          err_nx   = 1'b0;
        end
      end
      READ: begin
        if (cnt != n_words) begin
          w_ren_nx  = 1'b1;
          w_addr_nx = base + cnt[MW-1:0];
          cnt_nx    = cnt + CW'(1);
        end else if (!W_REN) begin
          // last read data is on W_RDATA now; compare against the folded-in value
          state_nx = CHECK;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          err_nx   = (rd_sig_nx != wr_sig);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      cnt        <= '0;
      base       <= '0;
      load_all_q <= 1'b0;
      verify_q   <= 1'b0;
      drain_q    <= 1'b0;
      rd_pend    <= 1'b0;
      wr_sig     <= '0;
      rd_sig     <= '0;
      data_q     <= '0;
      S_READY    <= 1'b0;
      W_WEN      <= 1'b0;
      W_REN      <= 1'b0;
      W_ADDR     <= '0;
      W_WDATA    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      base       <= base_nx;
      load_all_q <= load_all_nx;
      verify_q   <= verify_nx;
      drain_q    <= drain_nx;
      rd_pend    <= W_REN;
      wr_sig     <= wr_sig_nx;
      rd_sig     <= rd_sig_nx;
      data_q     <= data_nx;
      S_READY    <= s_ready_nx;
      W_WEN      <= w_wen_nx;
      W_REN      <= w_ren_nx;
      W_ADDR     <= w_addr_nx;
      W_WDATA    <= w_wdata_nx;
      BUSY       <= busy_nx;
      DONE       <= done_nx;
      ERR        <= err_nx;
    end
  end
endmodule

// File: tb/tb_weight_loader_cxy.sv
// Directed bench for weight_loader_cxy: weight-bank memory model with read corruption,
// event logs sampled on the falling edge, one task per scenario.
module tb_weight_loader_cxy;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        START = 1'b0;
  logic        LOAD_ALL = 1'b0;
  logic [2:0]  PHASE = 3'd0;
  logic        VERIFY = 1'b0;
  logic        S_VALID = 1'b0;
  logic [23:0] S_DATA = 24'h0;
  logic        S_READY, W_WEN, W_REN, BUSY, DONE, ERR;
  logic [6:0]  W_ADDR;
  logic [23:0] W_WDATA;
  logic [23:0] W_RDATA = 24'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic corrupt = 1'b0;
  logic log_clr = 1'b0;
  logic [23:0] mem [0:127];
  logic [23:0] wdat [0:127];

  weight_loader_cxy #(.DIM(16), .AW(4), .DW(24)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .LOAD_ALL(LOAD_ALL), .PHASE(PHASE),
    .VERIFY(VERIFY), .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY),
    .W_WEN(W_WEN), .W_REN(W_REN), .W_ADDR(W_ADDR), .W_WDATA(W_WDATA),
    .W_RDATA(W_RDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // bank model: data is written the cycle after its enable; reads return next cycle
  logic       pend_v = 1'b0;
  logic [6:0] pend_a = 7'h0;
  always @(posedge CLK) begin
    if (pend_v) mem[pend_a] = W_WDATA;
    pend_v = W_WEN;
    pend_a = W_ADDR;
    if (W_REN) W_RDATA <= mem[W_ADDR] ^ ((corrupt && W_ADDR == 7'h33) ? 24'h1 : 24'h0);
  end

  int          wen_cyc_q[$], ren_cyc_q[$], hs_cyc_q[$], done_cyc_q[$];
  logic [6:0]  wen_addr_q[$], ren_addr_q[$];
  logic [23:0] wdata_q[$];
  logic        hs_err_q[$], done_err_q[$], done_busy_q[$];
  int          both_cnt = 0;
  logic        wen_prev = 1'b0;
  always @(negedge CLK) begin
    if (log_clr) begin
      wen_cyc_q.delete(); ren_cyc_q.delete(); hs_cyc_q.delete(); done_cyc_q.delete();
      wen_addr_q.delete(); ren_addr_q.delete(); wdata_q.delete();
      hs_err_q.delete(); done_err_q.delete(); done_busy_q.delete();
      both_cnt = 0;
      wen_prev = 1'b0;
    end else begin
      if (wen_prev) wdata_q.push_back(W_WDATA);
      if (W_WEN) begin wen_cyc_q.push_back(cyc); wen_addr_q.push_back(W_ADDR); end
      if (W_REN) begin ren_cyc_q.push_back(cyc); ren_addr_q.push_back(W_ADDR); end
      if (S_VALID && S_READY) begin hs_cyc_q.push_back(cyc); hs_err_q.push_back(ERR); end
      if (DONE) begin done_cyc_q.push_back(cyc); done_err_q.push_back(ERR); done_busy_q.push_back(BUSY); end
      if (W_WEN && W_REN) both_cnt = both_cnt + 1;
      wen_prev = W_WEN;
    end
  end

  // pat 0: S_VALID always high; pat 1: S_VALID repeats 1,0,0,1. poke_at pulses START after the feed.
  task automatic drive_load(input logic la, input logic [2:0] ph, input logic vf, input int pat,
                            input int poke_at, output int st_cyc, output bit tmo);
    int k, t, pc, n;
    bit v, hs, dn;
    LOAD_ALL = la; PHASE = ph; VERIFY = vf; START = 1'b1; log_clr = 1'b1;
    st_cyc = cyc;
    @(posedge CLK); #1;
    START = 1'b0; log_clr = 1'b0;
    LOAD_ALL = ~la; PHASE = ~ph; VERIFY = ~vf;
    n = la ? 128 : 16;
    k = 0; t = 0; pc = 0;
    while (k < n && t < 2000) begin
      v = (pat == 0) || (pc % 4 == 0) || (pc % 4 == 3);
      pc++;
      S_VALID = v;
      S_DATA = v ? wdat[k] : 24'hABCDEF;
      @(negedge CLK); hs = v && S_READY;
      @(posedge CLK); #1;
      if (hs) k++;
      t++;
    end
    S_VALID = 1'b0;
    tmo = (k < n);
    t = 0; dn = 1'b0;
    while (!dn && t < 1000) begin
      START = (t == poke_at);
      @(negedge CLK); dn = DONE;
      @(posedge CLK); #1;
      t++;
    end
    START = 1'b0;
    if (!dn) tmo = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({S_READY, W_WEN, W_REN, BUSY, DONE, ERR, W_ADDR, W_WDATA} !== 37'h0) begin
      errors++; $display("FAIL reset_outputs got %0h want 0", {S_READY, W_WEN, W_REN, BUSY, DONE, ERR, W_ADDR, W_WDATA});
    end
    RSTn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({S_READY, W_WEN, W_REN, BUSY, DONE, ERR} !== 6'h0) begin
      errors++; $display("FAIL idle_outputs got %0h want 0", {S_READY, W_WEN, W_REN, BUSY, DONE, ERR});
    end
  endtask

  task automatic test_single_phase();
    int st; bit tmo;
    for (int i = 0; i < 16; i++) wdat[i] = 24'(i + 1);
    drive_load(1'b0, 3'd5, 1'b0, 0, -1, st, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL single_timeout got 1 want 0"); end
    checks++; if (wen_cyc_q.size() != 16 || wdata_q.size() != 16 || hs_cyc_q.size() != 16) begin
      errors++; $display("FAIL single_count got wen %0d wdata %0d hs %0d want 16", wen_cyc_q.size(), wdata_q.size(), hs_cyc_q.size());
    end else begin
      checks++; if (hs_cyc_q[0] != st + 1) begin errors++; $display("FAIL single_first_hs got %0d want %0d", hs_cyc_q[0], st + 1); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (wen_addr_q[i] !== 7'(8'h50 + i)) begin errors++; $display("FAIL single_addr[%0d] got %0h want %0h", i, wen_addr_q[i], 8'h50 + i); end
        checks++; if (wen_cyc_q[i] != hs_cyc_q[i] + 1) begin errors++; $display("FAIL single_wen_lag[%0d] got %0d want %0d", i, wen_cyc_q[i], hs_cyc_q[i] + 1); end
        checks++; if (wdata_q[i] !== 24'(i + 1)) begin errors++; $display("FAIL single_wdata[%0d] got %0h want %0h", i, wdata_q[i], i + 1); end
      end
      checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != hs_cyc_q[15] + 3) begin
        errors++; $display("FAIL single_done_cycle got n=%0d want one at %0d", done_cyc_q.size(), hs_cyc_q[15] + 3);
      end
    end
    checks++; if (done_cyc_q.size() != 1 || done_busy_q[0] !== 1'b0 || done_err_q[0] !== 1'b0) begin
      errors++; $display("FAIL single_done_flags got n=%0d want busy 0 err 0", done_cyc_q.size());
    end
    checks++; if (ren_cyc_q.size() != 0) begin errors++; $display("FAIL single_no_read got %0d want 0", ren_cyc_q.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[80 + i] !== 24'(i + 1)) begin errors++; $display("FAIL single_mem[%0d] got %0h want %0h", 80 + i, mem[80 + i], i + 1); end
    end
  endtask

  task automatic test_full_verify();
    int st; bit tmo;
    for (int i = 0; i < 128; i++) wdat[i] = 24'(i);
    drive_load(1'b1, 3'd0, 1'b1, 0, -1, st, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL full_timeout got 1 want 0"); end
    checks++; if (hs_cyc_q.size() != 128 || ren_cyc_q.size() != 128 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL full_count got hs %0d ren %0d done %0d want 128 128 1", hs_cyc_q.size(), ren_cyc_q.size(), done_cyc_q.size());
    end else begin
      checks++; if (ren_cyc_q[0] != hs_cyc_q[127] + 3) begin errors++; $display("FAIL full_first_ren got %0d want %0d", ren_cyc_q[0], hs_cyc_q[127] + 3); end
      for (int j = 0; j < 128; j++) begin
        checks++; if (ren_addr_q[j] !== 7'(j) || ren_cyc_q[j] != ren_cyc_q[0] + j) begin
          errors++; $display("FAIL full_ren[%0d] got addr %0h cyc %0d want addr %0h cyc %0d", j, ren_addr_q[j], ren_cyc_q[j], j, ren_cyc_q[0] + j);
        end
      end
      checks++; if (done_cyc_q[0] != ren_cyc_q[127] + 2) begin errors++; $display("FAIL full_done_lag got %0d want %0d", done_cyc_q[0], ren_cyc_q[127] + 2); end
      checks++; if (done_cyc_q[0] != st + 260) begin errors++; $display("FAIL full_load_time got %0d want %0d", done_cyc_q[0] - st, 260); end
      checks++; if (done_err_q[0] !== 1'b0) begin errors++; $display("FAIL full_err got %0b want 0", done_err_q[0]); end
    end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL full_wen_ren_overlap got %0d want 0", both_cnt); end
    for (int i = 0; i < 128; i += 9) begin
      checks++; if (mem[i] !== 24'(i)) begin errors++; $display("FAIL full_mem[%0d] got %0h want %0h", i, mem[i], i); end
    end
  endtask

  task automatic test_backpressure();
    int st; bit tmo;
    for (int i = 0; i < 16; i++) wdat[i] = 24'h200000 + 24'(i * 7);
    drive_load(1'b0, 3'd2, 1'b0, 1, -1, st, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++; if (wen_cyc_q.size() != 16 || hs_cyc_q.size() != 16) begin
      errors++; $display("FAIL bp_count got wen %0d hs %0d want 16", wen_cyc_q.size(), hs_cyc_q.size());
    end else begin
      checks++; if (hs_cyc_q[1] != st + 4 || hs_cyc_q[2] != st + 5) begin
        errors++; $display("FAIL bp_hs_spacing got %0d %0d want %0d %0d", hs_cyc_q[1], hs_cyc_q[2], st + 4, st + 5);
      end
      for (int i = 0; i < 16; i++) begin
        checks++; if (wen_cyc_q[i] != hs_cyc_q[i] + 1 || wen_addr_q[i] !== 7'(8'h20 + i)) begin
          errors++; $display("FAIL bp_wen[%0d] got cyc %0d addr %0h want cyc %0d addr %0h", i, wen_cyc_q[i], wen_addr_q[i], hs_cyc_q[i] + 1, 8'h20 + i);
        end
      end
      checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != hs_cyc_q[15] + 3) begin
        errors++; $display("FAIL bp_done got n=%0d want one at %0d", done_cyc_q.size(), hs_cyc_q[15] + 3);
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[32 + i] !== 24'h200000 + 24'(i * 7)) begin errors++; $display("FAIL bp_mem[%0d] got %0h want %0h", 32 + i, mem[32 + i], 24'h200000 + 24'(i * 7)); end
    end
  endtask

  task automatic test_corruption();
    int st; bit tmo;
    for (int i = 0; i < 16; i++) wdat[i] = 24'h5A5A00 + 24'(i);
    corrupt = 1'b1;
    drive_load(1'b0, 3'd3, 1'b1, 0, -1, st, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL corrupt_timeout got 1 want 0"); end
    checks++; if (done_cyc_q.size() != 1 || done_err_q[0] !== 1'b1) begin
      errors++; $display("FAIL corrupt_err got n=%0d want one DONE with ERR 1", done_cyc_q.size());
    end
    checks++; if (ren_cyc_q.size() != 16) begin errors++; $display("FAIL corrupt_reads got %0d want 16", ren_cyc_q.size()); end
    repeat (5) @(posedge CLK);
    #1;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL corrupt_err_sticky got %0b want 1", ERR); end
    corrupt = 1'b0;
    drive_load(1'b0, 3'd3, 1'b1, 0, -1, st, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL clean_timeout got 1 want 0"); end
    checks++; if (hs_err_q.size() == 0 || hs_err_q[0] !== 1'b0) begin errors++; $display("FAIL clean_err_cleared_on_start got n=%0d want ERR 0", hs_err_q.size()); end
    checks++; if (done_cyc_q.size() != 1 || done_err_q[0] !== 1'b0) begin errors++; $display("FAIL clean_err got n=%0d want one DONE with ERR 0", done_cyc_q.size()); end
  endtask

  task automatic test_reset_mid_write();
    int st; bit tmo;
    LOAD_ALL = 1'b0; PHASE = 3'd5; VERIFY = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; S_VALID = 1'b1; S_DATA = 24'hAAA000;
    for (int k = 1; k < 5; k++) begin
      @(posedge CLK); #1;
      S_DATA = 24'hAAA000 + 24'(k);
    end
    @(posedge CLK); #1;
    checks++; if (W_WEN !== 1'b1 || W_ADDR !== 7'h54) begin errors++; $display("FAIL rst_pre_wen got wen %0b addr %0h want 1 54", W_WEN, W_ADDR); end
    RSTn = 1'b0; S_DATA = 24'hBBBBBB;
    @(posedge CLK); #1;
    checks++;
    if ({S_READY, W_WEN, W_REN, BUSY, DONE, ERR, W_ADDR, W_WDATA} !== 37'h0) begin
      errors++; $display("FAIL rst_mid_outputs got %0h want 0", {S_READY, W_WEN, W_REN, BUSY, DONE, ERR, W_ADDR, W_WDATA});
    end
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (S_READY !== 1'b0 || W_WEN !== 1'b0) begin errors++; $display("FAIL rst_ready_low[%0d] got ready %0b wen %0b want 0 0", i, S_READY, W_WEN); end
    end
    @(posedge CLK); #1;
    S_VALID = 1'b0;
    checks++; if (mem[8'h53] !== 24'hAAA003) begin errors++; $display("FAIL rst_mem_53 got %0h want aaa003", mem[8'h53]); end
    checks++; if (mem[8'h54] !== 24'h0) begin errors++; $display("FAIL rst_mem_54 got %0h want 0", mem[8'h54]); end
    for (int i = 0; i < 16; i++) wdat[i] = 24'h300000 + 24'(i);
    drive_load(1'b0, 3'd5, 1'b1, 0, -1, st, tmo);
    checks++; if (tmo || done_cyc_q.size() != 1 || done_err_q[0] !== 1'b0) begin
      errors++; $display("FAIL rst_reload got tmo %0b done %0d want tmo 0 one clean DONE", tmo, done_cyc_q.size());
    end
    checks++; if (mem[8'h54] !== 24'h300004) begin errors++; $display("FAIL rst_reload_mem got %0h want 300004", mem[8'h54]); end
  endtask

  task automatic test_start_while_busy();
    int st; bit tmo;
    for (int i = 0; i < 16; i++) wdat[i] = 24'h0F0F00 ^ 24'(i * 3);
    drive_load(1'b0, 3'd6, 1'b1, 0, 8, st, tmo);
    repeat (30) @(posedge CLK);
    #1;
    checks++; if (tmo) begin errors++; $display("FAIL busy_timeout got 1 want 0"); end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", done_cyc_q.size()); end
    checks++; if (wen_cyc_q.size() != 16 || ren_cyc_q.size() != 16) begin
      errors++; $display("FAIL busy_counts got wen %0d ren %0d want 16 16", wen_cyc_q.size(), ren_cyc_q.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        checks++; if (ren_addr_q[j] !== 7'(8'h60 + j) || ren_cyc_q[j] != ren_cyc_q[0] + j) begin
          errors++; $display("FAIL busy_ren[%0d] got addr %0h cyc %0d want addr %0h cyc %0d", j, ren_addr_q[j], ren_cyc_q[j], 8'h60 + j, ren_cyc_q[0] + j);
        end
      end
    end
    checks++; if (BUSY !== 1'b0 || ERR !== 1'b0) begin errors++; $display("FAIL busy_final got busy %0b err %0b want 0 0", BUSY, ERR); end
  endtask

  initial begin
    test_reset();
    test_single_phase();
    test_full_verify();
    test_backpressure();
    test_corruption();
    test_reset_mid_write();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
